// File: rtl/iq_mixer_pkg.sv
// Shared types and elaboration-time helpers for the I/Q mixer: LO table generator,
// quadrant encoding and output width derivation.
package iq_mixer_pkg;

  typedef enum logic [1:0] {
    QUAD0 = 2'd0,
    QUAD1 = 2'd1,
    QUAD2 = 2'd2,
    QUAD3 = 2'd3
  } quad_e;

  localparam int     LUT_FRAC = 28;
  localparam longint PI_Q     = 64'sd843314857;

  function automatic int out_w(input int in_w, input int lo_w);
    return in_w + lo_w;
  endfunction

  // round(A*cos(pi/2*(i+0.5)/2^aw)) using a fixed-point Taylor series, so the table
  // folds to constants without relying on real-valued math at elaboration.
  function automatic longint lut_entry(input int i, input int aw, input int lo_w);
    longint x, x2, term, sum, amp;
    x    = (PI_Q * longint'(2 * i + 1)) >>> (aw + 2);
    x2   = (x * x) >>> LUT_FRAC;
    term = longint'(1) <<< LUT_FRAC;
    sum  = term;
    for (int k = 1; k <= 12; k++) begin
      term = -((term * x2) >>> LUT_FRAC) / longint'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (lo_w - 1)) - 1;
    return (amp * sum + (longint'(1) <<< (LUT_FRAC - 1))) >>> LUT_FRAC;
  endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave LO lookup: top phase bits in, registered signed cos/sin out.
module nco_quarter_lut
  import iq_mixer_pkg::*;
#(
  parameter int LUT_AW = 6,
  parameter int LO_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LUT_AW+1:0]        i_phase,
  output logic signed [LO_W-1:0]   o_cos,
  output logic signed [LO_W-1:0]   o_sin
);

  localparam int N = 2 ** LUT_AW;

  logic signed [LO_W-1:0] w_lut [N];
  logic signed [LO_W-1:0] w_a, w_b, w_cos, w_sin;
  quad_e                  w_quad;

  for (genvar g = 0; g < N; g++) begin : g_lut
    localparam longint V = lut_entry(g, LUT_AW, LO_W);
    assign w_lut[g] = LO_W'(V);
  end

  assign w_quad = quad_e'(i_phase[LUT_AW+1 -: 2]);

  // w_b reads the mirrored entry, giving the complementary quarter-wave
  if (LUT_AW > 0) begin : g_sel
    assign w_a = w_lut[i_phase[LUT_AW-1:0]];
    assign w_b = w_lut[~i_phase[LUT_AW-1:0]];
  end else begin : g_sel0
    assign w_a = w_lut[0];
    assign w_b = w_lut[0];
  end

  always_comb begin
    w_cos = w_a;
    w_sin = w_b;
    case (w_quad)
      QUAD0:   begin w_cos = w_a;  w_sin = w_b;  end
      QUAD1:   begin w_cos = -w_b; w_sin = w_a;  end
      QUAD2:   begin w_cos = -w_a; w_sin = -w_b; end
      QUAD3:   begin w_cos = w_b;  w_sin = -w_a; end
      default: begin w_cos = w_a;  w_sin = w_b;  end
    endcase
  end

  // stage 1: LO registered from the pre-edge phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cos <= '0;
      o_sin <= '0;
    end else begin
      o_cos <= w_cos;
      o_sin <= w_sin;
    end
  end

endmodule

// File: rtl/iq_mixer_nco.sv
// Quadrature down-mixer with integrated NCO: phase accumulator with double-buffered
// FCW, quarter-wave LO, two-stage pipeline producing valid-qualified I/Q.
module iq_mixer_nco
  import iq_mixer_pkg::*;
#(
  parameter int  PHASE_W = 32,
  parameter int  LUT_AW  = 6,
  parameter int  LO_W    = 8,
  parameter int  IN_W    = 1,
  localparam int OUT_W   = out_w(IN_W, LO_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [IN_W-1:0]           adc,
  input  logic [PHASE_W-1:0]        fcw,
  input  logic                      fcw_load,
  input  logic                      phase_clr,
  output logic [PHASE_W-1:0]        phase,
  output logic signed [OUT_W-1:0]   I,
  output logic signed [OUT_W-1:0]   Q,
  output logic                      valid
);

  logic [PHASE_W-1:0]      r_phase, r_fcw;
  logic signed [IN_W:0]    w_x, r_x_p1;
  logic                    r_vld_p1, r_vld_p2;
  logic signed [LO_W-1:0]  w_cos_p1, w_sin_p1;
  logic signed [OUT_W-1:0] r_i_p2, r_q_p2;

  // LO magnitude never reaches -2^(LO_W-1), so the product always fits OUT_W
  function automatic logic signed [OUT_W-1:0] mix(input logic signed [IN_W:0] x,
                                                  input logic signed [LO_W-1:0] lo,
                                                  input logic neg);
    logic signed [IN_W+LO_W:0] p;
    p = x * lo;
    if (neg) p = -p;
    return OUT_W'(p);
  endfunction

  always_comb begin
    if (IN_W == 1) w_x = adc[0] ? (IN_W + 1)'(1) : '1;
    else           w_x = {adc[IN_W-1], adc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_fcw   <= '0;
    end else begin
      if (phase_clr)  r_phase <= '0;
      else if (en)    r_phase <= r_phase + r_fcw;
      if (fcw_load)   r_fcw   <= fcw;
    end
  end

  nco_quarter_lut #(
    .LUT_AW (LUT_AW),
    .LO_W   (LO_W)
  ) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_phase (r_phase[PHASE_W-1 -: LUT_AW+2]),
    .o_cos   (w_cos_p1),
    .o_sin   (w_sin_p1)
  );

  // stage 1: sample and strobe captured alongside the LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_p1   <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_x_p1   <= w_x;
      r_vld_p1 <= en;
    end
  end

  // stage 2: products, held while no sample is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_p2   <= '0;
      r_q_p2   <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_i_p2 <= mix(r_x_p1, w_cos_p1, 1'b0);
        r_q_p2 <= mix(r_x_p1, w_sin_p1, 1'b1);
      end
    end
  end

  assign phase = r_phase;
  assign I     = r_i_p2;
  assign Q     = r_q_p2;
  assign valid = r_vld_p2;

endmodule

// File: tb/tb_iq_mixer_nco.sv
// Bench for iq_mixer_nco: default and legacy-square-LO instances against a
// real-math cycle reference model plus directed scenario checks.
module tb_iq_mixer_nco;

  localparam real PI = 3.14159265358979323846;

  logic        clk, rst_n, en, fcw_load, phase_clr;
  logic [0:0]  adc;
  logic [31:0] fcw;
  logic [31:0] phase_d, phase_l;
  logic signed [8:0] I_d, Q_d;
  logic signed [2:0] I_l, Q_l;
  logic        valid_d, valid_l;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] m_phase, m_fcw, m_s1_ph;
  logic        m_s1_vld, m_s1_adc, m_valid;
  int          m_I, m_Q, m_Il, m_Ql;

  iq_mixer_nco dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adc(adc), .fcw(fcw), .fcw_load(fcw_load),
    .phase_clr(phase_clr), .phase(phase_d), .I(I_d), .Q(Q_d), .valid(valid_d));

  iq_mixer_nco #(.LUT_AW(0), .LO_W(2)) dut_leg (
    .clk(clk), .rst_n(rst_n), .en(en), .adc(adc), .fcw(fcw), .fcw_load(fcw_load),
    .phase_clr(phase_clr), .phase(phase_l), .I(I_l), .Q(Q_l), .valid(valid_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  // LO sampled at the centre of the phase bin selected by the top aw+2 bits
  function automatic int lo_val(input logic [31:0] ph, input int aw, input int low, input bit want_sin);
    int  k;
    real th, a;
    k  = int'(ph >> (32 - (aw + 2)));
    th = 2.0 * PI * (real'(k) + 0.5) / real'(1 << (aw + 2));
    a  = real'((1 << (low - 1)) - 1);
    return rnd(a * (want_sin ? $sin(th) : $cos(th)));
  endfunction

  task automatic model_reset();
    m_phase = '0; m_fcw = '0; m_s1_ph = '0; m_s1_vld = 0; m_s1_adc = 0;
    m_valid = 0; m_I = 0; m_Q = 0; m_Il = 0; m_Ql = 0;
  endtask

  task automatic tick();
    int x;
    @(posedge clk);
    if (rst_n) begin
      m_valid = m_s1_vld;
      if (m_s1_vld) begin
        x    = m_s1_adc ? 1 : -1;
        m_I  =  x * lo_val(m_s1_ph, 6, 8, 0);
        m_Q  = -x * lo_val(m_s1_ph, 6, 8, 1);
        m_Il =  x * lo_val(m_s1_ph, 0, 2, 0);
        m_Ql = -x * lo_val(m_s1_ph, 0, 2, 1);
      end
      m_s1_vld = en; m_s1_adc = adc[0]; m_s1_ph = m_phase;
      if (phase_clr) m_phase = '0;
      else if (en)   m_phase = m_phase + m_fcw;
      if (fcw_load)  m_fcw = fcw;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; adc = 0; fcw = '0; fcw_load = 0; phase_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_run++; if (phase_d !== 32'h0) begin n_fail++; $display("FAIL reset_phase got %h want 0", phase_d); end
    n_run++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_d); end
    n_run++; if (I_d !== 9'sd0 || Q_d !== 9'sd0) begin n_fail++; $display("FAIL reset_iq got %0d/%0d want 0/0", I_d, Q_d); end
    rst_n = 1;
    fcw = 32'h0123_4567; fcw_load = 1; tick(); fcw_load = 0;
    en = 1;
    for (int i = 0; i < 6; i++) begin adc = 1'($urandom); tick(); end
    #2 rst_n = 0;
    #1;
    model_reset();
    n_run++; if (phase_d !== 32'h0 || phase_l !== 32'h0) begin n_fail++; $display("FAIL midreset_phase got %h want 0", phase_d); end
    n_run++; if (valid_d !== 1'b0 || valid_l !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", valid_d); end
    n_run++; if (I_d !== 9'sd0 || Q_d !== 9'sd0) begin n_fail++; $display("FAIL midreset_iq got %0d/%0d want 0/0", I_d, Q_d); end
    @(negedge clk);
    rst_n = 1; adc = 1;
    tick();
    n_run++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL release_valid1 got %b want 0", valid_d); end
    tick();
    n_run++; if (valid_d !== 1'b1) begin n_fail++; $display("FAIL release_valid2 got %b want 1", valid_d); end
    n_run++; if (I_d !== 9'sd127 || phase_d !== 32'h0) begin n_fail++; $display("FAIL release_data got I=%0d ph=%h want 127/0", I_d, phase_d); end
  endtask

  task automatic test_dc();
    fcw = '0; fcw_load = 1; phase_clr = 1; en = 1; adc = 1;
    tick();
    fcw_load = 0; phase_clr = 0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      n_run++; if (I_d !== 9'sd127 || Q_d !== -9'sd2 || valid_d !== 1'b1) begin
        n_fail++; $display("FAIL dc_pos got I=%0d Q=%0d v=%b want 127/-2/1", I_d, Q_d, valid_d); end
      tick();
    end
    adc = 0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      n_run++; if (I_d !== -9'sd127 || Q_d !== 9'sd2) begin
        n_fail++; $display("FAIL dc_neg got I=%0d Q=%0d want -127/2", I_d, Q_d); end
      tick();
    end
  endtask

  task automatic test_legacy();
    int itab [4] = '{1, -1, -1, 1};
    int qtab [4] = '{-1, -1, 1, 1};
    fcw = 32'h4000_0000; fcw_load = 1; phase_clr = 1; en = 1; adc = 1;
    tick();
    fcw_load = 0; phase_clr = 0;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      n_run++; if (I_l !== 3'(itab[k%4]) || Q_l !== 3'(qtab[k%4])) begin
        n_fail++; $display("FAIL legacy_pos[%0d] got I=%0d Q=%0d want %0d/%0d", k, I_l, Q_l, itab[k%4], qtab[k%4]); end
    end
    adc = 0;
    tick();
    for (int k = 9; k < 17; k++) begin
      tick();
      n_run++; if (I_l !== 3'(-itab[k%4]) || Q_l !== 3'(-qtab[k%4])) begin
        n_fail++; $display("FAIL legacy_neg[%0d] got I=%0d Q=%0d want %0d/%0d", k, I_l, Q_l, -itab[k%4], -qtab[k%4]); end
    end
  endtask

  task automatic test_fcw_buffer();
    fcw = 32'h100; fcw_load = 1; phase_clr = 1; en = 1;
    tick();
    fcw_load = 0; phase_clr = 0;
    tick();
    n_run++; if (phase_d !== 32'h100) begin n_fail++; $display("FAIL fcwbuf_a got %h want 100", phase_d); end
    fcw = 32'h1000; fcw_load = 1;
    tick();
    n_run++; if (phase_d !== 32'h200) begin n_fail++; $display("FAIL fcwbuf_b got %h want 200", phase_d); end
    fcw_load = 0;
    tick();
    n_run++; if (phase_d !== 32'h1200) begin n_fail++; $display("FAIL fcwbuf_c got %h want 1200", phase_d); end
  endtask

  task automatic test_wrap();
    logic [31:0] pexp [4] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0};
    int          iexp [4] = '{0, 127, -127, 127};
    fcw = 32'h8000_0000; fcw_load = 1; phase_clr = 1; en = 1; adc = 1;
    tick();
    fcw_load = 0; phase_clr = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_run++; if (phase_d !== pexp[k]) begin n_fail++; $display("FAIL wrap_phase[%0d] got %h want %h", k, phase_d, pexp[k]); end
      if (k > 0) begin
        n_run++; if (I_d !== 9'(iexp[k])) begin n_fail++; $display("FAIL wrap_I[%0d] got %0d want %0d", k, I_d, iexp[k]); end
      end
    end
    fcw = 32'hFFFF_FFFF; fcw_load = 1; phase_clr = 1;
    tick();
    fcw_load = 0; phase_clr = 0;
    tick();
    n_run++; if (phase_d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_ff1 got %h want ffffffff", phase_d); end
    tick();
    n_run++; if (phase_d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_ff2 got %h want fffffffe", phase_d); end
  endtask

  task automatic test_clr_load_en();
    logic vexp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    fcw = 32'h1234; fcw_load = 1; en = 1;
    tick(); fcw_load = 0;
    repeat (3) tick();
    fcw = 32'h55; fcw_load = 1; phase_clr = 1; en = 1;
    tick();
    n_run++; if (phase_d !== 32'h0) begin n_fail++; $display("FAIL cle_clr got %h want 0", phase_d); end
    fcw_load = 0; phase_clr = 0;
    tick();
    n_run++; if (phase_d !== 32'h55) begin n_fail++; $display("FAIL cle_inc got %h want 55", phase_d); end
    for (int k = 0; k < 4; k++) begin
      en = (k >= 2);
      adc = 1'($urandom);
      tick();
      n_run++; if (valid_d !== vexp[k]) begin n_fail++; $display("FAIL cle_valid[%0d] got %b want %b", k, valid_d, vexp[k]); end
      n_run++; if (I_d !== 9'(m_I) || Q_d !== 9'(m_Q)) begin
        n_fail++; $display("FAIL cle_hold[%0d] got %0d/%0d want %0d/%0d", k, I_d, Q_d, m_I, m_Q); end
      if (k < 2) begin
        n_run++; if (phase_d !== 32'h55 + ((k == 1) ? 32'h0 : 32'h0)) begin n_fail++; $display("FAIL cle_hold_phase got %h want 55", phase_d); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en        = ($urandom_range(0, 3) != 0);
      adc       = 1'($urandom);
      fcw       = $urandom;
      fcw_load  = ($urandom_range(0, 15) == 0);
      phase_clr = ($urandom_range(0, 31) == 0);
      tick();
      n_run++; if (phase_d !== m_phase || phase_l !== m_phase) begin
        n_fail++; $display("FAIL rand_phase[%0d] got %h/%h want %h", c, phase_d, phase_l, m_phase); end
      n_run++; if (valid_d !== m_valid || valid_l !== m_valid) begin
        n_fail++; $display("FAIL rand_valid[%0d] got %b/%b want %b", c, valid_d, valid_l, m_valid); end
      n_run++; if (I_d !== 9'(m_I) || Q_d !== 9'(m_Q)) begin
        n_fail++; $display("FAIL rand_iq[%0d] got %0d/%0d want %0d/%0d", c, I_d, Q_d, m_I, m_Q); end
      n_run++; if (I_l !== 3'(m_Il) || Q_l !== 3'(m_Ql)) begin
        n_fail++; $display("FAIL rand_leg_iq[%0d] got %0d/%0d want %0d/%0d", c, I_l, Q_l, m_Il, m_Ql); end
    end
    fcw_load = 0; phase_clr = 0;
  endtask

  initial begin
    test_reset();
    test_dc();
    test_legacy();
    test_fcw_buffer();
    test_wrap();
    test_clr_load_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_mixer_nco.md
# iq_mixer_nco

Parametrised quadrature down-mixer with integrated NCO for the FM receiver front end. Generalises the fixed 2-bit-phase, 1-bit-ADC I/Q modulator: it owns its phase accumulator and double-buffered frequency control word, uses a quarter-wave LO table of configurable resolution, accepts multi-bit ADC samples, and emits registered, valid-qualified I/Q products. Sits between the ADC sampler and the CIC decimator.

## Interface
- PHASE_W, 32, phase accumulator / FCW width (≥ LUT_AW+2)
- LUT_AW, 6, quarter-wave LUT address bits (0 allowed)
- LO_W, 8, signed LO amplitude width (≥ 2)
- IN_W, 1, ADC sample width; 1 = single-bit comparator
- OUT_W, IN_W+LO_W, derived, I/Q width (not overridable)

- clk  in  1  sampling clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  sample strobe: advance NCO and accept adc this cycle
- adc  in  IN_W  ADC sample (IN_W=1: 1→+1, 0→−1; else two's complement)
- fcw  in  PHASE_W  frequency control word (shadow value)
- fcw_load  in  1  capture fcw into active register
- phase_clr  in  1  synchronous accumulator clear
- phase  out  PHASE_W  current accumulator value
- I  out  OUT_W signed  x·cos(θ)
- Q  out  OUT_W signed  −x·sin(θ)
- valid  out  1  I/Q qualify

## Operation
- Reset (async assert, sync release): phase=0, fcw_active=0, all pipeline registers 0, I=Q=0, valid=0. Asserting rst_n low mid-stream clears everything immediately; no partial output afterwards.
- Per edge: phase_clr=1 → phase<=0 (priority over en); else en=1 → phase<=phase+fcw_active mod 2^PHASE_W; else hold.
- fcw_load=1 → fcw_active<=fcw on same edge; accumulation on that edge uses old fcw_active, new value from next edge. Load independent of en/phase_clr.
- LO: A=2^(LO_W−1)−1; LUT[i]=round(A·cos(π/2·(i+0.5)/2^LUT_AW)), i∈[0,2^LUT_AW). q=phase[PHASE_W−1:PHASE_W−2], idx=next LUT_AW bits, ~idx = bitwise inverse.
  - cos: q0 +LUT[idx], q1 −LUT[~idx], q2 −LUT[idx], q3 +LUT[~idx]
  - sin: q0 +LUT[~idx], q1 +LUT[idx], q2 −LUT[~idx], q3 −LUT[idx]
- LO never reaches −2^(LO_W−1) → products exact in OUT_W, no saturation. LUT_AW=0, LO_W=2 gives ±1 square LO (legacy behaviour).
- Sample taken on en edge k pairs with phase value present before edge k.

## Timing
- Stage 1 (edge k): register cos/sin from phase, register adc, en.
- Stage 2 (edge k+1): I<=x·cos, Q<=−x·sin, valid<=en delayed.
- Latency 2 clk from en sample edge to valid I/Q; throughput 1 sample/clk.
- I/Q hold last value while valid=0; downstream samples only on valid.
- phase_clr does not flush pipeline: two in-flight samples still emerge with old phase.

## Structure
- Package iq_mixer_pkg: LUT-generation function (elaborated constant), quadrant encoding enum, OUT_W derivation helper.
- Sub-module nco_quarter_lut (phase in → registered cos/sin out); mixer/pipeline in top.

## Test plan
- Reset: run with en=1, pulse rst_n low mid-stream → I=Q=0, valid=0, phase=0 same cycle; after release first valid exactly 2 clk after first en edge.
- Legacy: LUT_AW=0, LO_W=2, IN_W=1, load fcw=0x40000000, phase_clr, adc=1, en=1 → I=+1,−1,−1,+1 repeating, Q=−1,−1,+1,+1; adc=0 negates both.
- DC LO: defaults, fcw=0, phase_clr, adc=1 → I=127, Q=−2 (LUT[63]=2) constant; adc=0 → I=−127, Q=+2.
- FCW buffering: fcw_active=0x100, load 0x1000 at edge k with en=1 → phase +0x100 at k, +0x1000 at k+1.
- Wrap: fcw=0x80000000 from phase 0 → phase 0,0x80000000,0; I alternates +127/−127 with adc=1; fcw=0xFFFFFFFF from 0 → phase 0xFFFFFFFF, 0xFFFFFFFE.
- Simultaneous clr+load+en: phase=0 next cycle, new fcw applied next increment; en=0 cycles → phase held, valid gap propagates 2 clk later.
